fp_mult_pipe: RTL and testbench
===============================

Name: fp_mult_pipe

Overview:
- Parametrised, pipelined IEEE-754 binary floating-point multiplier. Successor to the single-cycle half-precision product path in the fma16 datapath.
- Adds IEEE rounding in all four modes, special-value handling, exception flags, and a valid/ready handshake with backpressure.
- Default configuration is binary16.
- Feeds the adder stage of the fused multiply-add and is also used standalone.

Parameters:
- EXPW, 5: exponent field width.
- MANW, 10: stored fraction width. Total width is W = 1+EXPW+MANW.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- x  in  W  multiplicand.
- y  in  W  multiplier.
- negp  in  1  negate product sign.
- roundmode  in  2  rounding mode: 00 RZ, 01 RNE, 10 RDN (toward -inf), 11 RUP (toward +inf).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- product  out  W  rounded product.
- flags  out  4  exception flags {NV, OF, UF, NX}.

Behaviour:
- Reset: all stage valid bits cleared; out_valid=0; product=0; flags=0. Reset is asynchronous, active-high, and takes effect mid-operation: in-flight ops are discarded and never emitted.
- Pipeline: 3 stages, so latency is 3 cycles from accepted input to out_valid when unstalled. Throughput is 1 op/cycle.
  - S1: unpack, classify, sign.
  - S2: (MANW+1)x(MANW+1) significand multiply and exponent sum.
  - S3: normalise, round, pack, flags.
- Handshake: advance = ~out_valid | out_ready, and in_ready = advance. Input is accepted when in_valid & in_ready.
  - All stages (valid bits and data) shift together on advance. Bubbles are not collapsed.
  - When advance=0, every stage holds and product/flags stay stable while out_valid=1.
  - roundmode and negp are captured with the operands and travel with them.
- Sign: x[W-1] ^ y[W-1] ^ negp. This applies to zero, inf and rounded results.
- Subnormal inputs (exp=0, frac≠0) are flushed to signed zero before multiplication. No flag is raised for the flush.
- Special cases, in priority order:
  1. Any NaN operand, or zero×inf: canonical qNaN {0, all-ones exp, 1 followed by MANW-1 zeros}. NV=1 for signalling NaN or zero×inf; NV=0 for quiet NaN input.
  2. inf×finite-nonzero or inf×inf: signed inf, flags 0.
  3. zero×finite: signed zero, flags 0.
- Exponent arithmetic: signed, width EXPW+2. Biased e = ex + ey − BIAS, where BIAS = 2^(EXPW-1)−1.
- Normalisation: if product bit 2MANW+1 is set, shift right 1 and increment e.
- Rounding:
  - Guard bit = first bit below the kept MANW; sticky = OR of the rest.
  - RNE rounds up on guard & (sticky | lsb). RUP rounds up on (guard|sticky) & ~sign. RDN rounds up on (guard|sticky) & sign. RZ never rounds up.
  - If the mantissa carries out on round-up, increment e.
- Overflow (e ≥ 2^EXPW−1 after rounding): OF=1, NX=1.
  - Result is inf for RNE, for RUP with positive sign, and for RDN with negative sign.
  - Otherwise the result is the max finite value, exp=all-ones−1, frac=all-ones.
- Underflow (e ≤ 0, before rounding): flush to signed zero with UF=1, NX=1. No subnormal outputs are produced.
- NX=1 whenever guard|sticky on a normal finite result.

Test Plan:
- Normal product: x=3E00, y=3E00, RNE, single op with out_ready=1 -> product 4080, flags 0000, out_valid exactly 3 cycles after acceptance.
- Rounding modes: x=3C01, y=3C01.
  - RZ -> 3C02, flags 0001. RNE -> 3C02, flags 0001. RUP -> 3C03, flags 0001.
  - With negp=1 and RDN -> BC03, flags 0001.
- Overflow: x=7BFF, y=7BFF.
  - RNE -> 7C00, flags 0101. RZ -> 7BFF, flags 0101.
- Specials:
  - x=0000, y=7C00 -> 7E00, flags 1000.
  - x=8000, y=3C00 -> 8000, flags 0000.
  - x=0400, y=0400 -> 0000, flags 0011.
- Backpressure: stream 6 back-to-back ops, hold out_ready=0 for 4 cycles starting when the first result appears. Required:
  - in_ready=0 during the stall.
  - product/flags stable while stalled.
  - all 6 results emitted in order with none lost or duplicated.
- Reset mid-stream: assert reset asynchronously with 3 ops in flight -> out_valid, product and flags go to 0 immediately. The next op after deassertion emits only its own correct result.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage IEEE-754 multiplier (binary16 by default)
// with four rounding modes, special values, flags and valid/ready flow.
module fp_mult_pipe #(
  parameter int EXPW = 5,
  parameter int MANW = 10,
  localparam int W = 1 + EXPW + MANW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         negp,
  input  logic [1:0]   roundmode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] product,
  output logic [3:0]   flags
);

  localparam int EW = EXPW + 2;
  localparam int PW = 2 * MANW + 2;
  localparam int BIAS = 2 ** (EXPW - 1) - 1;
  localparam logic signed [EW-1:0] EMAX = EW'(2 ** EXPW - 1);
  localparam logic signed [EW-1:0] EZERO = '0;

  logic advance;
  assign advance = ~out_valid | out_ready;
  assign in_ready = advance;

  // ---- S1: unpack, classify, sign ----
  logic [EXPW-1:0] xe, ye;
  logic [MANW-1:0] xf, yf;
  logic xz, yz, xi, yi, xn, yn, xs, ys, sgn, inv;
  assign xe = x[W-2:MANW];
  assign ye = y[W-2:MANW];
  assign xf = x[MANW-1:0];
  assign yf = y[MANW-1:0];
  assign xz = (xe == '0);
  assign yz = (ye == '0);
  assign xi = (xe == '1) && (xf == '0);
  assign yi = (ye == '1) && (yf == '0);
  assign xn = (xe == '1) && (xf != '0);
  assign yn = (ye == '1) && (yf != '0);
  assign xs = xn & ~xf[MANW-1];
  assign ys = yn & ~yf[MANW-1];
  assign sgn = x[W-1] ^ y[W-1] ^ negp;
  assign inv = (xz & yi) | (xi & yz);

  logic sp;
  logic [W-1:0] sp_res;
  logic [3:0] sp_flg;

  // Special-value result, resolved in priority order
  always_comb begin
    sp = 1'b0;
    sp_res = '0;
    sp_flg = '0;
    if (xn | yn | inv) begin
      sp = 1'b1;
      sp_res = {1'b0, {EXPW{1'b1}}, 1'b1, {(MANW-1){1'b0}}};
      sp_flg = {xs | ys | inv, 3'b000};
    end else if (xi | yi) begin
      sp = 1'b1;
      sp_res = {sgn, {EXPW{1'b1}}, {MANW{1'b0}}};
    end else if (xz | yz) begin
      sp = 1'b1;
      sp_res = {sgn, {(W-1){1'b0}}};
    end
  end

  logic v1, sgn1, sp1;
  logic [W-1:0] spr1;
  logic [3:0] spf1;
  logic [MANW:0] ma1, mb1;
  logic [EXPW-1:0] ex1, ey1;
  logic [1:0] rm1;

  logic v2, sgn2, sp2;
  logic [W-1:0] spr2;
  logic [3:0] spf2;
  logic [PW-1:0] p2;
  logic signed [EW-1:0] e2;
  logic [1:0] rm2;

  // ---- S3: normalise, round, pack ----
  logic norm, g, s, up, uf, of, to_inf;
  logic [PW-2:0] pn;
  logic [MANW-1:0] kept;
  logic [MANW:0] mr;
  logic signed [EW-1:0] en, er;
  logic [W-1:0] res;
  logic [3:0] flg;

  assign norm = p2[PW-1];
  assign pn = norm ? p2[PW-2:0] : {p2[PW-3:0], 1'b0};
  assign kept = pn[PW-2:MANW+1];
  assign g = pn[MANW];
  assign s = |pn[MANW-1:0];
  assign en = e2 + {{(EW-1){1'b0}}, norm};

  // Round-up decision for the selected mode
  always_comb begin
    up = 1'b0;
    unique case (rm2)
      2'b00: up = 1'b0;
      2'b01: up = g & (s | kept[0]);
      2'b10: up = (g | s) & sgn2;
      2'b11: up = (g | s) & ~sgn2;
      default: up = 1'b0;
    endcase
  end

  assign mr = {1'b0, kept} + {{MANW{1'b0}}, up};
  assign er = en + {{(EW-1){1'b0}}, mr[MANW]};
  assign uf = (en <= EZERO);
  assign of = (er >= EMAX);
  assign to_inf = (rm2 == 2'b01) | ((rm2 == 2'b11) & ~sgn2) |
                  ((rm2 == 2'b10) & sgn2);

  // Final result and flag selection
  always_comb begin
    res = '0;
    flg = '0;
    if (sp2) begin
      res = spr2;
      flg = spf2;
    end else if (uf) begin
      res = {sgn2, {(W-1){1'b0}}};
      flg = 4'b0011;
    end else if (of) begin
      flg = 4'b0101;
      if (to_inf)
        res = {sgn2, {EXPW{1'b1}}, {MANW{1'b0}}};
      else
        res = {sgn2, {(EXPW-1){1'b1}}, 1'b0, {MANW{1'b1}}};
    end else begin
      res = {sgn2, er[EXPW-1:0], mr[MANW-1:0]};
      flg = {3'b000, g | s};
    end
  end

  // Whole pipeline shifts in lockstep on advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      sgn1 <= 1'b0;
      sp1 <= 1'b0;
      spr1 <= '0;
      spf1 <= '0;
      ma1 <= '0;
      mb1 <= '0;
      ex1 <= '0;
      ey1 <= '0;
      rm1 <= '0;
      v2 <= 1'b0;
      sgn2 <= 1'b0;
      sp2 <= 1'b0;
      spr2 <= '0;
      spf2 <= '0;
      p2 <= '0;
      e2 <= '0;
      rm2 <= '0;
      out_valid <= 1'b0;
      product <= '0;
      flags <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      sgn1 <= sgn;
      sp1 <= sp;
      spr1 <= sp_res;
      spf1 <= sp_flg;
      ma1 <= {1'b1, xf};
      mb1 <= {1'b1, yf};
      ex1 <= xe;
      ey1 <= ye;
      rm1 <= roundmode;
      v2 <= v1;
      sgn2 <= sgn1;
      sp2 <= sp1;
      spr2 <= spr1;
      spf2 <= spf1;
      p2 <= PW'(ma1) * PW'(mb1);
      e2 <= {2'b00, ex1} + {2'b00, ey1} - EW'(BIAS);
      rm2 <= rm1;
      out_valid <= v2;
      product <= res;
      flags <= flg;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed and randomized checks of fp_mult_pipe
// against an arithmetic reference model (binary16).
module tb_fp_mult_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic negp = 1'b0;
  logic [1:0] roundmode = 2'b01;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [15:0] product;
  logic [3:0] flags;

  int n_tests = 0;
  int n_fail = 0;
  int n_out = 0;
  logic [19:0] exp_q[$];
  logic prev_stall = 1'b0;
  logic [19:0] prev_val = '0;
  logic last_acc = 1'b0;

  fp_mult_pipe dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x(x),
    .y(y),
    .negp(negp),
    .roundmode(roundmode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product(product),
    .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [23:0] obs, logic [23:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Reference: {flags, product} from value-level arithmetic
  function automatic logic [19:0] ref_mul(logic [15:0] a, logic [15:0] b,
                                          logic n, logic [1:0] rm);
    int ea, eb, fa, fb, e, sh;
    longint p, q, r, half;
    bit sg, na, nb, sa, sb, ia, ib, za, zb, up, inx;
    sg = a[15] ^ b[15] ^ n;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    fa = int'(a[9:0]);
    fb = int'(b[9:0]);
    na = (ea == 31) && (fa != 0);
    nb = (eb == 31) && (fb != 0);
    sa = na && (fa < 512);
    sb = nb && (fb < 512);
    ia = (ea == 31) && (fa == 0);
    ib = (eb == 31) && (fb == 0);
    za = (ea == 0);
    zb = (eb == 0);
    if (na || nb || (za && ib) || (ia && zb))
      return {sa || sb || (za && ib) || (ia && zb), 3'b000, 16'h7E00};
    if (ia || ib) return {4'b0000, sg, 15'h7C00};
    if (za || zb) return {4'b0000, sg, 15'h0000};
    p = longint'(1024 + fa) * longint'(1024 + fb);
    e = ea + eb - 15;
    sh = 10;
    if (p >= (64'sd1 << 21)) begin
      sh = 11;
      e = e + 1;
    end
    if (e <= 0) return {4'b0011, sg, 15'h0000};
    q = p >> sh;
    r = p - (q << sh);
    half = 64'sd1 << (sh - 1);
    inx = (r != 0);
    case (rm)
      2'b01: up = (r > half) || ((r == half) && (q % 2 == 1));
      2'b11: up = inx && !sg;
      2'b10: up = inx && sg;
      default: up = 1'b0;
    endcase
    q = q + (up ? 1 : 0);
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    if (e >= 31) begin
      if (rm == 2'b01 || (rm == 2'b11 && !sg) || (rm == 2'b10 && sg))
        return {4'b0101, sg, 15'h7C00};
      return {4'b0101, sg, 15'h7BFF};
    end
    return {3'b000, inx, sg, 5'(e), 10'(q - 1024)};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] tbl [10];
    tbl = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00,
            16'h7D00, 16'h0001, 16'h7BFF, 16'h0400, 16'h3C00};
    case ($urandom_range(0, 3))
      0: return tbl[$urandom_range(0, 9)];
      1: return {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
      2: return {1'($urandom), 5'($urandom_range(6, 24)), 10'($urandom)};
      default: return 16'($urandom);
    endcase
  endfunction

  // One op on an idle pipe; checks latency and result
  task automatic run_one(string tag, logic [15:0] a, logic [15:0] b,
                         logic n, logic [1:0] rm, logic [19:0] want);
    int lat;
    x = a;
    y = b;
    negp = n;
    roundmode = rm;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = 16'($urandom);
    y = 16'($urandom);
    negp = ~n;
    roundmode = ~rm;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 24'(lat), 24'd3);
    chk(tag, {4'h0, flags, product}, {4'h0, want});
    @(posedge clk);
    #1;
  endtask

  // One streaming cycle: scoreboard, stall hold, in_ready
  task automatic step();
    logic [19:0] cur;
    logic [19:0] e;
    @(negedge clk);
    cur = {flags, product};
    last_acc = in_valid && in_ready;
    if (last_acc) exp_q.push_back(ref_mul(x, y, negp, roundmode));
    if (prev_stall)
      chk("stall_hold", {3'b0, out_valid, cur}, {4'b0001, prev_val});
    if (out_valid && !out_ready)
      chk("stall_in_ready", 24'(in_ready), 24'd0);
    if (out_valid && out_ready) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL extra_out observed=%h expected=none", cur);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stream", {4'h0, cur}, {4'h0, e});
        n_out++;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_val = cur;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ax [6];
    logic [15:0] bx [6];
    logic [1:0] rx [6];
    int sent, stall, cyc, acc;
    bit seen;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {3'b0, out_valid, flags, product}, 24'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_one("normal", 16'h3E00, 16'h3E00, 1'b0, 2'b01, 20'h0_4080);
    run_one("rz", 16'h3C01, 16'h3C01, 1'b0, 2'b00, 20'h1_3C02);
    run_one("rne", 16'h3C01, 16'h3C01, 1'b0, 2'b01, 20'h1_3C02);
    run_one("rup", 16'h3C01, 16'h3C01, 1'b0, 2'b11, 20'h1_3C03);
    run_one("rdn_neg", 16'h3C01, 16'h3C01, 1'b1, 2'b10, 20'h1_BC03);
    run_one("of_rne", 16'h7BFF, 16'h7BFF, 1'b0, 2'b01, 20'h5_7C00);
    run_one("of_rz", 16'h7BFF, 16'h7BFF, 1'b0, 2'b00, 20'h5_7BFF);
    run_one("zero_inf", 16'h0000, 16'h7C00, 1'b0, 2'b01, 20'h8_7E00);
    run_one("neg_zero", 16'h8000, 16'h3C00, 1'b0, 2'b01, 20'h0_8000);
    run_one("underflow", 16'h0400, 16'h0400, 1'b0, 2'b01, 20'h3_0000);
    run_one("qnan", 16'h7E00, 16'h3C00, 1'b0, 2'b01, 20'h0_7E00);
    run_one("snan", 16'h7D00, 16'h3C00, 1'b0, 2'b01, 20'h8_7E00);
    run_one("subn_flush", 16'h0001, 16'hBC00, 1'b0, 2'b01, 20'h0_8000);

    // Backpressure: 6 ops, 4-cycle stall at first result
    for (int i = 0; i < 6; i++) begin
      ax[i] = rand_op();
      bx[i] = rand_op();
      rx[i] = 2'($urandom);
    end
    exp_q.delete();
    n_out = 0;
    prev_stall = 1'b0;
    sent = 0;
    stall = 0;
    cyc = 0;
    seen = 1'b0;
    while ((sent < 6 || n_out < 6) && cyc < 60) begin
      if (out_valid) seen = 1'b1;
      out_ready = !(seen && stall < 4);
      if (seen && stall < 4) stall++;
      in_valid = (sent < 6);
      if (sent < 6) begin
        x = ax[sent];
        y = bx[sent];
        roundmode = rx[sent];
        negp = 1'b0;
      end
      step();
      if (last_acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 24'(n_out), 24'd6);
    chk("bp_stalls", 24'(stall), 24'd4);
    chk("bp_left", 24'(exp_q.size()), 24'd0);

    // Randomized streaming with random backpressure
    exp_q.delete();
    n_out = 0;
    acc = 0;
    prev_stall = 1'b0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      x = rand_op();
      y = rand_op();
      negp = 1'($urandom);
      roundmode = 2'($urandom);
      step();
      if (last_acc) acc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("rand_count", 24'(n_out), 24'(acc));

    // Reset with three ops in flight
    repeat (3) @(posedge clk);
    #1;
    x = 16'h3E00;
    y = 16'h3E00;
    roundmode = 2'b01;
    negp = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("pre_rst_valid", 24'(out_valid), 24'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async", {3'b0, out_valid, flags, product}, 24'h0);
    @(posedge clk);
    #1;
    chk("rst_hold", {3'b0, out_valid, flags, product}, 24'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_one("post_rst", 16'h3C01, 16'h3C01, 1'b0, 2'b11, 20'h1_3C03);
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_idle", 24'(out_valid), 24'd0);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
